// File: rtl/prca_pkg.sv
// Shared constants and types for the pipelined ripple-carry adder/subtractor.
package prca_pkg;

  localparam int unsigned PRCA_DEF_WIDTH  = 32;
  localparam int unsigned PRCA_DEF_STAGES = 4;

  // Width of the slice each pipeline stage ripples through.
  function automatic int unsigned prca_chunk_width(input int unsigned width,
                                                   input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Stage register layout for the default configuration: occupancy, chunk
  // carry, partial sum so far, and the operands still to be consumed.
  typedef struct packed {
    logic                      valid;
    logic                      carry;
    logic [PRCA_DEF_WIDTH-1:0] sum;
    logic [PRCA_DEF_WIDTH-1:0] a;
    logic [PRCA_DEF_WIDTH-1:0] b;
  } prca_stage_t;

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its
// top bit so the final stage can derive signed overflow.
module rca_chunk
  import prca_pkg::*;
#(
  parameter int unsigned CHUNK = prca_chunk_width(PRCA_DEF_WIDTH, PRCA_DEF_STAGES)
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  // Bit-serial ripple: full adder per bit, carry chained upward.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// WIDTH bits are split into STAGES chunks; each stage ripples one chunk and
// registers the partial sum and carry, so the cycle time is one chunk ripple.
// Optional macro PRCA_OVERFLOW_EN adds the out_ovf signed-overflow output.
module pipelined_rca
  import prca_pkg::*;
#(
  parameter int unsigned WIDTH  = PRCA_DEF_WIDTH,
  parameter int unsigned STAGES = PRCA_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PRCA_OVERFLOW_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned CHUNK = prca_chunk_width(WIDTH, STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  // Same layout as prca_stage_t, sized to this instance's WIDTH.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  if ((STAGES == 0) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $fatal(1, "pipelined_rca: WIDTH must be a non-zero multiple of STAGES");
  end

  stage_t [STAGES-1:0] q;
  logic   [STAGES-1:0] v;
  logic   [STAGES-1:0] adv;
  logic   [STAGES-1:0] load;
  logic   [STAGES:0]   room;
  logic   [STAGES-1:0] cmsb;

  // Ready ripples back from out_ready: a stage may take a beat when it is
  // empty or its current occupant is moving on this cycle.
  always_comb begin
    room         = '0;
    adv          = '0;
    load         = '0;
    room[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv[k]  = v[k] && room[k+1];
      room[k] = !v[k] || adv[k];
    end
    load[0] = in_valid && room[0];
    for (int k = 1; k < int'(STAGES); k++) begin
      load[k] = adv[k-1];
    end
  end

  assign in_ready = room[0];

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic             c_in;
    logic [CHUNK-1:0] s;
    logic             co;
    stage_t           nxt;
    stage_t           st;

    if (k == 0) begin : g_first
      // Stage 0 sees the raw operands; subtraction inverts B and the carry.
      always_comb begin
        a_in   = in_a;
        b_in   = in_b ^ {WIDTH{in_sub}};
        c_in   = in_cin ^ in_sub;
        sum_in = '0;
      end
    end else begin : g_rest
      // Later stages continue from the previous stage's registers.
      always_comb begin
        a_in   = q[k-1].a;
        b_in   = q[k-1].b;
        c_in   = q[k-1].carry;
        sum_in = q[k-1].sum;
      end
    end

    rca_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a    (a_in[k*CHUNK +: CHUNK]),
      .b    (b_in[k*CHUNK +: CHUNK]),
      .cin  (c_in),
      .s    (s),
      .cout (co),
      .cmsb (cmsb[k])
    );

    // Merge this stage's chunk into the travelling partial sum.
    always_comb begin
      nxt                          = '0;
      nxt.valid                    = 1'b1;
      nxt.carry                    = co;
      nxt.sum                      = sum_in;
      nxt.sum[k*CHUNK +: CHUNK]    = s;
      nxt.a                        = a_in;
      nxt.b                        = b_in;
    end

    // Stage register: load on handoff, empty when the occupant leaves.
    always_ff @(posedge clk) begin
      if (rst) begin
        st <= '0;
      end else if (load[k]) begin
        st <= nxt;
      end else if (adv[k]) begin
        st.valid <= 1'b0;
      end
    end

    assign q[k] = st;
    assign v[k] = st.valid;
  end

  assign out_valid = q[LAST].valid;
  assign out_sum   = q[LAST].sum;
  assign out_cout  = q[LAST].carry;

`ifdef PRCA_OVERFLOW_EN
  logic msb_cin_q;

  // Carry into bit WIDTH-1, captured together with the final chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      msb_cin_q <= 1'b0;
    end else if (load[LAST]) begin
      msb_cin_q <= cmsb[LAST];
    end
  end

  assign out_ovf = msb_cin_q ^ q[LAST].carry;
`endif

  // Operand copies in the final stage and intermediate chunk top-carries have
  // no consumer.
  logic unused_tail;
  assign unused_tail = ^{cmsb, q[LAST].a, q[LAST].b};

endmodule
